// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: pipeline-side inputs plus stall/flush/debug outputs.
// Perf-counter signals exist only when PERF_CNT_EN is defined.
interface hazard_unit_mc_if #(
  parameter int unsigned REG_W = 5
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
);
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic             branch_d;
  logic             jump_d;
  logic             pcsrc_d;
  logic [REG_W-1:0] rt_e;
  logic [REG_W-1:0] writereg_e;
  logic             regwrite_e;
  logic             memtoreg_e;
  logic [REG_W-1:0] writereg_m;
  logic             memtoreg_m;
  logic             memread_m;
  logic             memwrite_m;
  logic             memready_m;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             mem_timeout;
  logic [1:0]       mem_state;
`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] perf_mem_stalls;
  logic [PERF_W-1:0] perf_data_stalls;
`endif

  modport slave (
`ifdef PERF_CNT_EN
    output perf_mem_stalls,
    output perf_data_stalls,
`endif
    input  rs_d, rt_d, branch_d, jump_d, pcsrc_d,
    input  rt_e, writereg_e, regwrite_e, memtoreg_e,
    input  writereg_m, memtoreg_m, memread_m, memwrite_m, memready_m,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output mem_timeout, mem_state
  );

  modport master (
`ifdef PERF_CNT_EN
    input  perf_mem_stalls,
    input  perf_data_stalls,
`endif
    output rs_d, rt_d, branch_d, jump_d, pcsrc_d,
    output rt_e, writereg_e, regwrite_e, memtoreg_e,
    output writereg_m, memtoreg_m, memread_m, memwrite_m, memready_m,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  mem_timeout, mem_state
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage pipeline with multi-cycle data memory and a request watchdog.
// Optional stall perf counters are enabled by defining PERF_CNT_EN.
module hazard_unit_mc #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 32,
  parameter int unsigned CNT_W       = 6
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned PERF_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  hazard_unit_mc_if.slave   hz
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr  = 2'd2
  } mem_state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic [REG_W-1:0] rs_d, rt_d, rt_e, writereg_e, writereg_m;
  logic             rs_nz, rt_nz;
  logic             lw_haz, br_haz, data_stall;
  logic             req, mem_stall;

  assign rs_d       = hz.rs_d;
  assign rt_d       = hz.rt_d;
  assign rt_e       = hz.rt_e;
  assign writereg_e = hz.writereg_e;
  assign writereg_m = hz.writereg_m;

  // $zero is hard-wired, so a zero specifier never creates a dependency.
  assign rs_nz = |rs_d;
  assign rt_nz = |rt_d;

  assign lw_haz = hz.memtoreg_e &
                  ((rs_nz && (rt_e == rs_d)) || (rt_nz && (rt_e == rt_d)));

  assign br_haz = hz.branch_d &
                  ((hz.regwrite_e &
                    ((rs_nz && (writereg_e == rs_d)) || (rt_nz && (writereg_e == rt_d)))) |
                   (hz.memtoreg_m &
                    ((rs_nz && (writereg_m == rs_d)) || (rt_nz && (writereg_m == rt_d)))));

  assign data_stall = lw_haz | br_haz;

  assign req = hz.memread_m | hz.memwrite_m;

  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle:  mem_stall = req & ~hz.memready_m;
      StWait:  mem_stall = ~hz.memready_m;
      StErr:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Counter holds the number of stalled cycles already spent on the pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !hz.memready_m) begin
            state_q <= StWait;
            cnt_q   <= CNT_W'(1);
          end
        end
        StWait: begin
          if (hz.memready_m) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= StErr;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StErr: begin
          state_q   <= StErr;
          timeout_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_w = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.stall_m = 1'b1;
        hz.flush_w = 1'b1;
      end else if (data_stall) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end else begin
        hz.flush_d = hz.pcsrc_d | hz.jump_d;
      end
    end
  end

  assign hz.mem_timeout = timeout_q;
  assign hz.mem_state   = state_q;

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] perf_mem_q;
  logic [PERF_W-1:0] perf_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_mem_q  <= '0;
      perf_data_q <= '0;
    end else begin
      if (mem_stall && !(&perf_mem_q)) begin
        perf_mem_q <= perf_mem_q + PERF_W'(1);
      end
      if (!mem_stall && data_stall && !(&perf_data_q)) begin
        perf_data_q <= perf_data_q + PERF_W'(1);
      end
    end
  end

  assign hz.perf_mem_stalls  = perf_mem_q;
  assign hz.perf_data_stalls = perf_data_q;
`endif

endmodule
